srl_fifo: RTL and testbench
===========================

// Module: srl_fifo
//
// PURPOSE
//   Synchronous FIFO whose storage is a 32-deep addressable shift register per
//   data bit (two 16-deep SRL stages chained, taps joined by a 2:1 mux on
//   address bit 4). A write shifts every bit plane by one. The read side
//   addresses the oldest entry at tap COUNT-1. This turns the shift-in,
//   tap-out primitive into a valid/ready stream buffer for the MegaWing
//   Spartan-3 designs.
//
// PARAMETERS
//   WIDTH   8    data bits per entry; one 32-deep shift chain per bit
//   DEPTH   32   fixed at 32 (two chained 16-deep SRL stages); any other value is illegal
//
// PORTS
//   CLKIN     in   1        single clock; all state changes on its rising edge
//   RESETN    in   1        reset, synchronous, active-low
//   WR_DATA   in   WIDTH    data to push
//   WR_VALID  in   1        producer offers WR_DATA
//   WR_READY  out  1        FIFO can accept; push = WR_VALID & WR_READY
//   RD_DATA   out  WIDTH    oldest entry (combinational tap read)
//   RD_VALID  out  1        RD_DATA holds a real entry
//   RD_READY  in   1        consumer takes RD_DATA; pop = RD_VALID & RD_READY
//   COUNT     out  6        occupancy, 0..32
//
// BEHAVIOUR
//   - Reset (RESETN=0 at an edge): COUNT=0, RD_VALID=0, WR_READY=1 from the next cycle.
//     Shift-register contents are not reset and are don't-care. RD_DATA is
//     don't-care while RD_VALID=0.
//   - Reset mid-operation discards all entries; a push or pop in that same cycle is ignored.
//   - Storage: a push shifts all taps up by one (tap k -> k+1) and writes WR_DATA
//     into tap 0. The shift enable is the push qualifier; no other event shifts.
//   - Read address: rd_addr = COUNT-1, 5 bits. Bit 4 selects the upper 16-deep stage,
//     bits 3:0 select the tap within a stage. RD_DATA = tap[rd_addr].
//     rd_addr is don't-care when COUNT=0.
//   - COUNT update per edge:
//       push & !pop -> +1;  pop & !push -> -1;  push & pop -> unchanged;  neither -> unchanged.
//     With push & pop, the shift moves the new oldest entry into tap COUNT-1,
//     so no address correction is required.
//   - Flags are pure decodes of the registered COUNT:
//       RD_VALID = (COUNT != 0);  WR_READY = (COUNT != 32).
//     There is no combinational path from RD_READY to WR_READY or from WR_VALID to RD_VALID.
//   - Latency: a word pushed into an empty FIFO has RD_VALID=1 in the next cycle.
//     A pop takes effect at the edge, and the next entry is visible right after it.
//   - Full (COUNT=32): WR_READY=0, so a push is impossible even when a pop occurs in
//     the same cycle. No write-through bypass.
//   - Empty (COUNT=0): RD_VALID=0, so a pop is impossible. A push in the same cycle
//     is a plain push.
//   - Overflow and underflow cannot occur. A WR_VALID with WR_READY=0 is held by the
//     producer and has no effect on state.
//   - Throughput: one push and one pop per cycle, sustained at any COUNT in 1..31.
//
// STRUCTURE
//   - Shared package srl_pkg: SRL_STAGE_DEPTH=16, SRL_DEPTH=32, SRL_ADDR_W=5,
//     COUNT_W=6, and the address-split constants (stage select = bit 4).
//   - Sub-module srl32_bit: one bit plane.
//       Ports: CLK, CE, D, A[4:0], Q.
//       Contents: two chained 16-deep SRL stages (the Q15 cascade feeds the second
//       stage's D) and a MUXF5-style select on A[4].
//       Instantiated WIDTH times in a generate loop, with CE = push.
//   - Top level holds only the COUNT register, the push/pop qualifiers, the
//     flag decodes and the rd_addr subtraction.
//
// TESTING
//   1. Reset: hold RESETN=0 for 2 cycles with WR_VALID=1
//      -> COUNT=0, RD_VALID=0, WR_READY=1 after the release edge; nothing stored.
//   2. Push 0x11, 0x22, 0x33 with RD_READY=0
//      -> COUNT=3, RD_DATA=0x11. Pop once -> RD_DATA=0x22, COUNT=2.
//   3. Fill with 0x00..0x1F -> COUNT=32, WR_READY=0.
//      Then drive WR_VALID=1 with 0xFF -> ignored.
//      Drain 32 words -> 0x00..0x1F in order; RD_VALID=0 after the last pop.
//   4. Stage boundary: push until COUNT=17, then pop
//      -> the word read from tap 16 (upper stage) is correct, and the next word
//      comes from tap 15 (lower stage).
//   5. Simultaneous push/pop at COUNT=5 for 40 cycles with an incrementing pattern
//      -> COUNT stays 5 and the output is the input delayed by 5 pops, with no gaps.
//   6. Push into empty with RD_READY=1 held
//      -> RD_VALID rises in the next cycle and the word pops at the following edge;
//      COUNT goes 0->1->0.
//      Also pulse RESETN=0 while COUNT=10 -> COUNT=0 next cycle.

Source files
------------

// File: rtl/srl_pkg.sv
// Shared constants for the SRL-based FIFO.
// Address split: bit 4 picks the stage, bits 3:0 the tap.
package srl_pkg;

    localparam int SRL_STAGE_DEPTH = 16;
    localparam int SRL_DEPTH       = 32;
    localparam int SRL_ADDR_W      = 5;
    localparam int SRL_TAP_W       = 4;
    localparam int SRL_STAGE_SEL   = 4;
    localparam int COUNT_W         = 6;

    localparam logic [COUNT_W-1:0] COUNT_EMPTY = '0;
    localparam logic [COUNT_W-1:0] COUNT_FULL  = COUNT_W'(SRL_DEPTH);

endpackage

// File: rtl/srl32_bit.sv
// One bit plane: two chained 16-deep shift stages,
// tap selected by a 16:1 read per stage and a 2:1 stage mux.
module srl32_bit
    import srl_pkg::*;
(
    input  logic                  CLK,
    input  logic                  CE,
    input  logic                  D,
    input  logic [SRL_ADDR_W-1:0] A,
    output logic                  Q
);

    logic [SRL_STAGE_DEPTH-1:0] stage_lo;
    logic [SRL_STAGE_DEPTH-1:0] stage_hi;
    logic                       q_lo;
    logic                       q_hi;

    // Shift both stages; the lower stage's last tap cascades upward.
    always_ff @(posedge CLK) begin
        if (CE) begin
            stage_lo <= {stage_lo[SRL_STAGE_DEPTH-2:0], D};
            stage_hi <= {stage_hi[SRL_STAGE_DEPTH-2:0],
                         stage_lo[SRL_STAGE_DEPTH-1]};
        end
    end

    // Tap read inside each stage, then stage select on the top address bit.
    always_comb begin
        q_lo = stage_lo[A[SRL_TAP_W-1:0]];
        q_hi = stage_hi[A[SRL_TAP_W-1:0]];
        Q    = A[SRL_STAGE_SEL] ? q_hi : q_lo;
    end

endmodule

// File: rtl/srl_fifo.sv
// Valid/ready FIFO built from addressable shift registers.
// Oldest entry always sits at tap COUNT-1.
module srl_fifo
    import srl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic               CLKIN,
    input  logic               RESETN,
    input  logic [WIDTH-1:0]   WR_DATA,
    input  logic               WR_VALID,
    output logic               WR_READY,
    output logic [WIDTH-1:0]   RD_DATA,
    output logic               RD_VALID,
    input  logic               RD_READY,
    output logic [COUNT_W-1:0] COUNT
);

    generate
        if (DEPTH != SRL_DEPTH) begin : g_bad_depth
            $error("srl_fifo: DEPTH must be 32");
        end
    endgenerate

    logic [COUNT_W-1:0]    count;
    logic                  push;
    logic                  pop;
    logic [SRL_ADDR_W-1:0] rd_addr;

    // Handshake qualifiers; flags come only from the registered count.
    always_comb begin
        RD_VALID = (count != COUNT_EMPTY);
        WR_READY = (count != COUNT_FULL);
        push     = WR_VALID & WR_READY;
        pop      = RD_VALID & RD_READY;
        rd_addr  = count[SRL_ADDR_W-1:0] - SRL_ADDR_W'(1);
        COUNT    = count;
    end

    // Occupancy: reset wins over any same-cycle push or pop.
    always_ff @(posedge CLKIN) begin
        if (!RESETN) begin
            count <= COUNT_EMPTY;
        end else begin
            unique case ({push, pop})
                2'b10:   count <= count + COUNT_W'(1);
                2'b01:   count <= count - COUNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // One shift chain per data bit, all shifting on push.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_plane
            srl32_bit u_plane (
                .CLK (CLKIN),
                .CE  (push),
                .D   (WR_DATA[gi]),
                .A   (rd_addr),
                .Q   (RD_DATA[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_srl_fifo.sv
// Self-checking bench for srl_fifo against a queue model.
// Directed steps followed by a random push/pop run.
module tb_srl_fifo;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [5:0] count;

    int total = 0;
    int bad   = 0;

    logic [7:0] model_q[$];

    always #5 clk = ~clk;

    srl_fifo #(.WIDTH(8), .DEPTH(32)) dut (
        .CLKIN    (clk),
        .RESETN   (rstn),
        .WR_DATA  (wr_data),
        .WR_VALID (wr_valid),
        .WR_READY (wr_ready),
        .RD_DATA  (rd_data),
        .RD_VALID (rd_valid),
        .RD_READY (rd_ready),
        .COUNT    (count)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int n;
        n = model_q.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(n != 0));
        chk({tag, ".wr_ready"}, 32'(wr_ready), 32'(n != 32));
        if (n != 0)
            chk({tag, ".rd_data"}, 32'(rd_data), 32'(model_q[0]));
    endtask

    // Drive one cycle from a negedge, update the model at the edge,
    // then check at the following negedge.
    task automatic cyc(input string tag, input logic rn, input logic wv,
                       input logic [7:0] wd, input logic rr);
        bit do_push;
        bit do_pop;
        rstn     = rn;
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        do_pop   = rr && (model_q.size() > 0);
        do_push  = wv && (model_q.size() < 32);
        @(posedge clk);
        if (!rn) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(wd);
        end
        @(negedge clk);
        check_state(tag);
    endtask

    initial begin
        rstn     = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        @(negedge clk);

        // 1: reset held with WR_VALID asserted
        cyc("rst0", 1'b0, 1'b1, 8'hAA, 1'b0);
        cyc("rst1", 1'b0, 1'b1, 8'hBB, 1'b0);
        cyc("idle", 1'b1, 1'b0, 8'h00, 1'b0);

        // 2: three pushes, one pop
        cyc("p11", 1'b1, 1'b1, 8'h11, 1'b0);
        cyc("p22", 1'b1, 1'b1, 8'h22, 1'b0);
        cyc("p33", 1'b1, 1'b1, 8'h33, 1'b0);
        chk("three.count", 32'(count), 32'd3);
        chk("three.data", 32'(rd_data), 32'h11);
        cyc("pop1", 1'b1, 1'b0, 8'h00, 1'b1);
        chk("pop1.data", 32'(rd_data), 32'h22);
        chk("pop1.count", 32'(count), 32'd2);
        cyc("drn1", 1'b1, 1'b0, 8'h00, 1'b1);
        cyc("drn2", 1'b1, 1'b0, 8'h00, 1'b1);

        // 3: fill, blocked push, then drain in order
        for (int i = 0; i < 32; i++)
            cyc("fill", 1'b1, 1'b1, 8'(i), 1'b0);
        chk("full.count", 32'(count), 32'd32);
        chk("full.wr_ready", 32'(wr_ready), 32'd0);
        cyc("blocked", 1'b1, 1'b1, 8'hFF, 1'b0);
        cyc("full_pp", 1'b1, 1'b1, 8'hFF, 1'b1);
        cyc("refill", 1'b1, 1'b1, 8'h1F, 1'b0);
        for (int i = 0; i < 32; i++) begin
            chk("drain.order", 32'(rd_data),
                (i < 31) ? 32'(i + 1) : 32'h1F);
            cyc("drain", 1'b1, 1'b0, 8'h00, 1'b1);
        end
        chk("drained.rd_valid", 32'(rd_valid), 32'd0);

        // 4: stage boundary at COUNT=17
        for (int i = 0; i < 17; i++)
            cyc("fill17", 1'b1, 1'b1, 8'(8'h40 + i), 1'b0);
        chk("c17.tap16", 32'(rd_data), 32'h40);
        cyc("pop_t16", 1'b1, 1'b0, 8'h00, 1'b1);
        chk("c16.tap15", 32'(rd_data), 32'h41);
        for (int i = 0; i < 16; i++)
            cyc("drain17", 1'b1, 1'b0, 8'h00, 1'b1);

        // 5: simultaneous push/pop at COUNT=5
        for (int i = 0; i < 5; i++)
            cyc("fill5", 1'b1, 1'b1, 8'(8'h80 + i), 1'b0);
        for (int i = 5; i < 45; i++) begin
            cyc("stream", 1'b1, 1'b1, 8'(8'h80 + i), 1'b1);
            chk("stream.count", 32'(count), 32'd5);
            chk("stream.delay", 32'(rd_data), 32'(8'(8'h80 + i - 4)));
        end
        for (int i = 0; i < 5; i++)
            cyc("drain5", 1'b1, 1'b0, 8'h00, 1'b1);

        // 6: push into empty with RD_READY held, then reset pulse
        cyc("lat.push", 1'b1, 1'b1, 8'hA5, 1'b1);
        chk("lat.count1", 32'(count), 32'd1);
        cyc("lat.pop", 1'b1, 1'b0, 8'h00, 1'b1);
        chk("lat.count0", 32'(count), 32'd0);
        for (int i = 0; i < 10; i++)
            cyc("fill10", 1'b1, 1'b1, 8'(8'hC0 + i), 1'b0);
        cyc("rst_mid", 1'b0, 1'b1, 8'hEE, 1'b1);
        chk("rst_mid.count", 32'(count), 32'd0);

        // Random push/pop traffic with varying bias
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = (i < 200) ? 75 : (i < 400) ? 25 : 50;
            cyc("rand", 1'b1,
                ($urandom_range(99) < bias),
                8'($urandom),
                ($urandom_range(99) >= bias));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
